osc_meas_sequencer: RTL and testbench
=====================================

Name: osc_meas_sequencer

Overview:
Sequences one gated frequency measurement on one of the ring-oscillator counters (inverter chain, C-element chain, compound C-element chain). It performs four steps in order:
- clear the selected counter;
- enable it for a programmable number of clk cycles;
- disable it and let the asynchronous count settle;
- capture the count through a synchronizer and stream it out LSB-first as bytes over a valid/ready handshake.

It sits between the top-level pin decode and the counter instances. It replaces direct enable pins and the live-count output mux.

Parameters:
NUM_OSC, 3, number of oscillator counters (osc_en width)
COUNT_W, 24, counter width; must be a multiple of 8
GATE_W, 16, width of gate_cycles
CLR_CYCLES, 2, clk cycles osc_clr is held high
SETTLE_CYCLES, 4, clk cycles between enable drop and capture; must be >= 3

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a measurement; sampled only in IDLE
abort  input  1  cancel the measurement in progress
osc_sel  input  2  counter index 0..NUM_OSC-1
gate_cycles  input  GATE_W  enable window length in clk cycles
count_in  input  COUNT_W  asynchronous count from all counters (externally muxed by osc_en)
osc_en  output  NUM_OSC  one-hot oscillator enable
osc_clr  output  1  active-high counter clear
byte_data  output  8  result byte
byte_valid  output  1  byte_data valid
byte_ready  input  1  consumer accepts byte
result  output  COUNT_W  last captured count, held
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last byte is accepted
err  output  1  sticky request error

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs are 0, including result.
  - Byte index is 0. Both synchronizer stages are 0.
- count_in passes through a 2-flop synchronizer continuously.
- IDLE, on a clk edge with start=1:
  - If osc_sel >= NUM_OSC or gate_cycles == 0: set err=1 and stay in IDLE.
  - Otherwise: clear err, latch osc_sel and gate_cycles, go to CLEAR.
- CLEAR: osc_clr=1, osc_en=0, for exactly CLR_CYCLES cycles, then RUN.
- RUN: osc_en[sel]=1 and all other bits 0, for exactly gate_cycles cycles, then SETTLE.
- SETTLE: osc_en=0 for exactly SETTLE_CYCLES cycles.
  - On the last SETTLE cycle, result takes the synchronizer output.
  - The state then goes to SEND with byte index 0.
- SEND:
  - byte_valid=1 and byte_data=result[8*idx+7:8*idx].
  - byte_data is stable while byte_valid=1 and byte_ready=0.
  - On valid&&ready, idx increments. If the accepted byte was index COUNT_W/8-1, the next cycle is IDLE with byte_valid=0, done=1 for one cycle, and idx=0.
  - Back-to-back acceptance (ready held high) sends one byte per cycle.
- Latency: take the edge that samples a valid start as edge 0.
  - osc_clr is high for cycles 1..CLR_CYCLES.
  - osc_en is high for the next gate_cycles cycles.
  - The first byte_valid appears in cycle CLR_CYCLES+gate_cycles+SETTLE_CYCLES+1.
- abort=1 on a clk edge in any non-IDLE state:
  - Next state is IDLE; osc_en, osc_clr and byte_valid drop to 0; idx=0.
  - done stays 0, result is unchanged and err is unchanged.
  - abort has priority over every other transition, including the final byte acceptance in the same cycle.
- start while busy is ignored. abort in IDLE is ignored.
- gate_cycles and osc_sel changes after latching have no effect until the next start.
- osc_en is never asserted while osc_clr=1. At most one osc_en bit is ever high.
- Counter wrap inside the oscillator is not detected; result is the raw modulo-2^COUNT_W value.

Test Plan:
1. Bench counter model increments once per clk while enabled. Start with sel=0, gate=100, ready=1 -> osc_clr high for cycles 1-2, osc_en=3'b001 for cycles 3-102, byte_valid from cycle 107, bytes 0x64,0x00,0x00 on consecutive cycles, then done pulse, result=24'h000064.
2. sel=2, gate=0x1234, ready toggling 1 of every 3 cycles -> osc_en=3'b100 only; bytes 0x34,0x12,0x00; each byte held stable until its accept.
3. start with sel=3 -> err=1 and busy stays 0. Then start with sel=1, gate=5 -> err clears and bytes 0x05,0x00,0x00 follow.
4. abort asserted in RUN after 10 cycles -> next cycle IDLE, osc_en=0, no bytes, done=0, result keeps its previous value.
5. rst_n low during SEND after 1 byte, then released -> all outputs 0 immediately (async). A new sel=0, gate=1 run yields bytes 0x01,0x00,0x00.
6. Model preloaded to 24'hFFFFFF before CLEAR, clear honoured, gate=3 -> result=24'h000003. start pulses during RUN/SEND do not restart the sequence.

Source files
------------

// File: rtl/osc_meas_sequencer.sv
// Gated ring-oscillator frequency measurement: clear, enable for N clk cycles,
// settle, capture the synchronized count and stream it out LSB-first as bytes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; validates osc_sel / gate_cycles
// S_CLEAR  | osc_clr high for CLR_CYCLES cycles
// S_RUN    | selected osc_en bit high for gate_cycles cycles
// S_SETTLE | all enables low; async count settles, result captured on last cycle
// S_SEND   | result streamed out over byte_valid/byte_ready, LSB first
module osc_meas_sequencer #(
    parameter int NUM_OSC       = 3,
    parameter int COUNT_W       = 24,
    parameter int GATE_W        = 16,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         osc_sel,
    input  logic [GATE_W-1:0]  gate_cycles,
    input  logic [COUNT_W-1:0] count_in,
    output logic [NUM_OSC-1:0] osc_en,
    output logic               osc_clr,
    output logic [7:0]         byte_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic [COUNT_W-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int NBYTES = COUNT_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMR_W  = (GATE_W > 8) ? GATE_W : 8;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [NUM_OSC-1:0] EN_ONE   = NUM_OSC'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_SEND
    } state_t;

    state_t             state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [1:0]         sel_q;
    logic [GATE_W-1:0]  gate_q;
    logic [COUNT_W-1:0] sync1_q, sync2_q;
    logic [COUNT_W-1:0] result_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_OSC-1:0] osc_en_q;
    logic               osc_clr_q;
    logic [7:0]         byte_data_q;
    logic               byte_valid_q;
    logic               done_q;
    logic               err_q;

    logic [IDX_W-1:0]   idx_d;
    logic [7:0]         byte_nxt_d;

    always_comb begin
        idx_d      = idx_q + 1'b1;
        byte_nxt_d = 8'(result_q >> {idx_d, 3'b000});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            sel_q        <= '0;
            gate_q       <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            result_q     <= '0;
            idx_q        <= '0;
            osc_en_q     <= '0;
            osc_clr_q    <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync1_q <= count_in;
            sync2_q <= sync1_q;
            done_q  <= 1'b0;
            // abort outranks every transition, including the final byte accept
            if (state_q != S_IDLE && abort) begin
                state_q      <= S_IDLE;
                osc_en_q     <= '0;
                osc_clr_q    <= 1'b0;
                byte_valid_q <= 1'b0;
                byte_data_q  <= '0;
                idx_q        <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (32'(osc_sel) >= NUM_OSC || gate_cycles == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                err_q     <= 1'b0;
                                sel_q     <= osc_sel;
                                gate_q    <= gate_cycles;
                                osc_clr_q <= 1'b1;
                                tmr_q     <= TMR_W'(CLR_CYCLES - 1);
                                state_q   <= S_CLEAR;
                            end
                        end
                    end
                    S_CLEAR: begin
                        if (tmr_q == '0) begin
                            osc_clr_q <= 1'b0;
                            osc_en_q  <= EN_ONE << sel_q;
                            tmr_q     <= TMR_W'(gate_q - 1'b1);
                            state_q   <= S_RUN;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (tmr_q == '0) begin
                            osc_en_q <= '0;
                            tmr_q    <= TMR_W'(SETTLE_CYCLES - 1);
                            state_q  <= S_SETTLE;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        // sync2 holds the post-gate count once SETTLE_CYCLES >= 3
                        if (tmr_q == '0) begin
                            result_q     <= sync2_q;
                            byte_data_q  <= sync2_q[7:0];
                            byte_valid_q <= 1'b1;
                            idx_q        <= '0;
                            state_q      <= S_SEND;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (byte_ready) begin
                            if (idx_q == LAST_IDX) begin
                                byte_valid_q <= 1'b0;
                                byte_data_q  <= '0;
                                idx_q        <= '0;
                                done_q       <= 1'b1;
                                state_q      <= S_IDLE;
                            end else begin
                                idx_q       <= idx_d;
                                byte_data_q <= byte_nxt_d;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign osc_en     = osc_en_q;
    assign osc_clr    = osc_clr_q;
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign result     = result_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_osc_meas_sequencer.sv
// Bench for osc_meas_sequencer: directed vector table, hand-written abort/reset
// sequences and randomized runs against an oscillator counter model.
module tb_osc_meas_sequencer;

    localparam int CLR    = 2;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  osc_sel = '0;
    logic [15:0] gate_cycles = '0;
    logic [23:0] count_in;
    logic [2:0]  osc_en;
    logic        osc_clr;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic [23:0] result;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // oscillator counter: cleared by osc_clr, +1 per clk while enabled
    logic [23:0] cnt;
    logic        preload_req = 1'b1;
    logic [23:0] preload_val = '0;
    assign count_in = cnt;

    always @(posedge clk) begin
        if (osc_clr)            cnt <= '0;
        else if (osc_en != '0)  cnt <= cnt + 1'b1;
        else if (preload_req)   cnt <= preload_val;
    end

    always #5 clk = ~clk;

    osc_meas_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .osc_sel(osc_sel), .gate_cycles(gate_cycles), .count_in(count_in),
        .osc_en(osc_en), .osc_clr(osc_clr), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .result(result),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] gate;
        int          rmode;
        bit          preload;
        bit          poke;
        logic [23:0] exp_res;
    } vec_t;

    vec_t vecs[4];
    logic [23:0] last_res = '0;

    // One full measurement; timing expectations come straight from the latency rules.
    task automatic measure(input logic [1:0] sel, input logic [15:0] gate, input int rmode,
                           input bit preload, input bit poke, input logic [23:0] exp_res,
                           input string tag);
        int cyc, clr_f, clr_l, en_f, en_l, en_bad, v_f, unstable, done_cyc, last_acc, budget;
        int done_busy;
        logic [7:0] got[$];
        logic prev_v, prev_acc, rdy;
        logic [7:0] prev_d;
        logic [23:0] res_at_done;
        if (preload) begin
            @(negedge clk);
            preload_val = 24'hFFFFFF;
            preload_req = 1'b1;
            @(negedge clk);
            preload_req = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        start = 1'b1; osc_sel = sel; gate_cycles = gate; byte_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        osc_sel = 2'($urandom);
        gate_cycles = 16'($urandom);
        clr_f = -1; clr_l = -1; en_f = -1; en_l = -1; en_bad = 0; v_f = -1;
        unstable = 0; done_cyc = -1; last_acc = -1; done_busy = -1; res_at_done = '0;
        prev_v = 1'b0; prev_acc = 1'b0; prev_d = '0;
        budget = int'(gate) + 100;
        cyc = 1;
        while (cyc < budget && done_cyc < 0) begin
            if (osc_clr) begin if (clr_f < 0) clr_f = cyc; clr_l = cyc; end
            if (osc_en != '0) begin
                if (en_f < 0) en_f = cyc;
                en_l = cyc;
                if (osc_en != (3'b001 << sel) || osc_clr) en_bad++;
            end
            if (byte_valid && v_f < 0) v_f = cyc;
            if (prev_v && !prev_acc && (!byte_valid || byte_data !== prev_d)) unstable++;
            if (done) begin done_cyc = cyc; done_busy = int'(busy); res_at_done = result; end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            byte_ready = rdy;
            if (poke) begin
                start = (cyc == 5) || byte_valid;
                osc_sel = 2'd0;
                gate_cycles = 16'd1;
            end
            if (byte_valid && rdy) begin got.push_back(byte_data); last_acc = cyc; end
            prev_v = byte_valid; prev_acc = rdy; prev_d = byte_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; byte_ready = 1'b0;
        chk({tag, " done_seen"}, done_cyc >= 0, 1);
        chk({tag, " done_one_cycle"}, done, 1'b0);
        chk({tag, " clr_first"}, clr_f, 1);
        chk({tag, " clr_last"}, clr_l, CLR);
        chk({tag, " en_first"}, en_f, CLR + 1);
        chk({tag, " en_last"}, en_l, CLR + int'(gate));
        chk({tag, " en_value_bad"}, en_bad, 0);
        chk({tag, " first_valid"}, v_f, CLR + int'(gate) + SETTLE + 1);
        chk({tag, " byte_unstable"}, unstable, 0);
        chk({tag, " byte_count"}, got.size(), 3);
        for (int b = 0; b < 3; b++)
            chk($sformatf("%s byte%0d", tag, b), (b < got.size()) ? got[b] : 8'h00, exp_res[8*b +: 8]);
        chk({tag, " done_after_last_accept"}, done_cyc, last_acc + 1);
        chk({tag, " busy_at_done"}, done_busy, 0);
        chk({tag, " result"}, res_at_done, exp_res);
        chk({tag, " err_clear"}, err, 1'b0);
        last_res = exp_res;
    endtask

    initial begin
        int n;
        vecs[0] = '{sel: 2'd0, gate: 16'd100,    rmode: 0, preload: 1'b0, poke: 1'b0, exp_res: 24'h000064};
        vecs[1] = '{sel: 2'd2, gate: 16'h1234,   rmode: 1, preload: 1'b0, poke: 1'b0, exp_res: 24'h001234};
        vecs[2] = '{sel: 2'd1, gate: 16'd5,      rmode: 0, preload: 1'b0, poke: 1'b0, exp_res: 24'h000005};
        vecs[3] = '{sel: 2'd1, gate: 16'd3,      rmode: 2, preload: 1'b1, poke: 1'b1, exp_res: 24'h000003};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {osc_en, osc_clr, byte_data, byte_valid, busy, done, err}, '0);
        chk("reset_result", result, 24'h0);
        rst_n = 1'b1;
        preload_req = 1'b0;
        @(negedge clk);

        // invalid requests: bad select, then zero gate
        start = 1'b1; osc_sel = 2'd3; gate_cycles = 16'd10;
        @(negedge clk);
        start = 1'b0;
        chk("err_bad_sel", err, 1'b1);
        chk("err_bad_sel_busy", busy, 1'b0);
        @(negedge clk);
        chk("err_sticky", err, 1'b1);
        start = 1'b1; osc_sel = 2'd0; gate_cycles = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("err_zero_gate_busy", busy, 1'b0);

        for (int i = 0; i < 4; i++)
            measure(vecs[i].sel, vecs[i].gate, vecs[i].rmode, vecs[i].preload, vecs[i].poke,
                    vecs[i].exp_res, $sformatf("vec%0d", i));

        // abort after 10 RUN cycles
        @(negedge clk);
        start = 1'b1; osc_sel = 2'd0; gate_cycles = 16'd50;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (CLR + 9) @(negedge clk);
        chk("abort_in_run", osc_en, 3'b001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_en", osc_en, 3'b000);
        n = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (byte_valid || done) n++;
        end
        chk("abort_no_bytes", n, 0);
        chk("abort_result_kept", result, last_res);
        chk("abort_err_kept", err, 1'b0);

        // abort coinciding with final byte acceptance
        start = 1'b1; osc_sel = 2'd1; gate_cycles = 16'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!byte_valid && n < 60) begin @(negedge clk); n++; end
        chk("abtfin_valid", byte_valid, 1'b1);
        byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; byte_ready = 1'b0;
        chk("abtfin_done", done, 1'b0);
        chk("abtfin_valid_drop", byte_valid, 1'b0);
        chk("abtfin_busy", busy, 1'b0);
        chk("abtfin_result", result, 24'h000001);

        // async reset in the middle of SEND
        start = 1'b1; osc_sel = 2'd0; gate_cycles = 16'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!byte_valid && n < 60) begin @(negedge clk); n++; end
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        chk("rst_mid_send_valid", byte_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {osc_en, osc_clr, byte_data, byte_valid, busy, done, err}, '0);
        chk("rst_async_result", result, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        measure(2'd0, 16'd1, 0, 1'b0, 1'b0, 24'h000001, "post_rst");

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  s;
            logic [15:0] g;
            s = 2'($urandom_range(0, 2));
            g = 16'($urandom_range(1, 400));
            measure(s, g, 2, 1'b0, 1'b0, 24'(g), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
